// File: rtl/synch_ctrl.sv
// synch_ctrl: sequencing controller for the receiver synchronisation chain.
// Watches the coarse-timing metric stream (|P| against R), detects the
// preamble plateau, fires the one-shot frequency-offset enable, arms fine
// timing and reports lock or timeout for each frame. All control lives in
// one FSM; every output is a flop updated together with the state register.
module synch_ctrl #(
  parameter int MAG_W    = 24,
  parameter int THR_W    = 5,
  parameter int PLAT_LEN = 48,
  parameter int MISS_MAX = 2,
  parameter int SRCH_TO  = 4096,
  parameter int FINE_TO  = 256,
  parameter int CNT_W    = 13
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             cyc_i,
  input  logic             ena,
  input  logic [MAG_W-1:0] P_mag,
  input  logic [MAG_W-1:0] R_metric,
  input  logic [THR_W-1:0] thres,
  input  logic             fine_done,
  input  logic             fine_fail,
  output logic             time_syn_run,
  output logic             freoff_ena,
  output logic             fine_arm,
  output logic             lock,
  output logic             tout,
  output logic [2:0]       state_o
);

  // Product width: MAG_W bits of R times a 5-bit saturated threshold.
  // The left side (P << 4) fits in MAG_W+4 bits, so MAG_W+5 holds both
  // sides of the comparison without truncation.
  localparam int PROD_W = MAG_W + 5;

  localparam logic [CNT_W-1:0] SRCH_LAST = CNT_W'(SRCH_TO - 1);
  localparam logic [CNT_W-1:0] FINE_LAST = CNT_W'(FINE_TO - 1);
  localparam logic [CNT_W-1:0] PLAT_LAST = CNT_W'(PLAT_LEN - 1);
  localparam logic [CNT_W-1:0] MISS_LAST = CNT_W'(MISS_MAX);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEARCH    = 3'd1,
    ST_PLATEAU   = 3'd2,
    ST_WAIT_FINE = 3'd3,
    ST_LOCKED    = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] plat_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic [CNT_W-1:0] to_cnt;
  logic [4:0]       thres_sat;
  logic             hit;

  // Plateau hit test: (P << 4) >= R * thres, evaluated at full width.
  function automatic logic hit_test(input logic [MAG_W-1:0] p,
                                    input logic [MAG_W-1:0] r,
                                    input logic [4:0]       t);
    logic [PROD_W-1:0] lhs;
    logic [PROD_W-1:0] rhs;
    lhs = {1'b0, p, 4'b0000};
    rhs = PROD_W'(r) * PROD_W'(t);
    return (lhs >= rhs);
  endfunction

  // Clamp the threshold numerator to 16 (threshold of 1.0).
  always_comb begin
    thres_sat = 5'd0;
    if (int'(thres) > 16) begin
      thres_sat = 5'd16;
    end else begin
      thres_sat = 5'(thres);
    end
  end

  assign hit     = hit_test(P_mag, R_metric, thres_sat);
  assign state_o = state;

  // Synchronisation FSM: state, counters and all registered outputs.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state        <= ST_IDLE;
      plat_cnt     <= '0;
      miss_cnt     <= '0;
      to_cnt       <= '0;
      time_syn_run <= 1'b0;
      freoff_ena   <= 1'b0;
      fine_arm     <= 1'b0;
      lock         <= 1'b0;
      tout         <= 1'b0;
    end else if (!cyc_i) begin
      // Frame abort: back to IDLE, nothing pending survives.
      state        <= ST_IDLE;
      plat_cnt     <= '0;
      miss_cnt     <= '0;
      to_cnt       <= '0;
      time_syn_run <= 1'b0;
      freoff_ena   <= 1'b0;
      fine_arm     <= 1'b0;
      lock         <= 1'b0;
      tout         <= 1'b0;
    end else begin
      // Pulse outputs default low; only the deciding branch raises them.
      freoff_ena <= 1'b0;
      tout       <= 1'b0;
      case (state)
        ST_IDLE: begin
          state        <= ST_SEARCH;
          plat_cnt     <= '0;
          miss_cnt     <= '0;
          to_cnt       <= '0;
          time_syn_run <= 1'b1;
          fine_arm     <= 1'b0;
          lock         <= 1'b0;
        end

        ST_SEARCH: begin
          time_syn_run <= 1'b1;
          fine_arm     <= 1'b0;
          lock         <= 1'b0;
          if (ena) begin
            if (hit) begin
              // A hit on the timeout sample still starts a plateau.
              state    <= ST_PLATEAU;
              plat_cnt <= CNT_W'(1);
              miss_cnt <= '0;
              to_cnt   <= '0;
            end else if (to_cnt == SRCH_LAST) begin
              tout   <= 1'b1;
              to_cnt <= '0;
            end else begin
              to_cnt <= to_cnt + CNT_W'(1);
            end
          end else begin
            to_cnt <= to_cnt;
          end
        end

        ST_PLATEAU: begin
          time_syn_run <= 1'b1;
          fine_arm     <= 1'b0;
          lock         <= 1'b0;
          if (ena) begin
            if (hit) begin
              miss_cnt <= '0;
              if (plat_cnt == PLAT_LAST) begin
                // Plateau confirmed: one-shot frequency-offset start.
                state      <= ST_WAIT_FINE;
                freoff_ena <= 1'b1;
                fine_arm   <= 1'b1;
                plat_cnt   <= '0;
                to_cnt     <= '0;
              end else begin
                plat_cnt <= plat_cnt + CNT_W'(1);
              end
            end else if (miss_cnt == MISS_LAST) begin
              // One miss too many: the plateau was not real.
              state    <= ST_SEARCH;
              plat_cnt <= '0;
              miss_cnt <= '0;
              to_cnt   <= '0;
            end else begin
              miss_cnt <= miss_cnt + CNT_W'(1);
            end
          end else begin
            plat_cnt <= plat_cnt;
          end
        end

        ST_WAIT_FINE: begin
          time_syn_run <= 1'b1;
          fine_arm     <= 1'b1;
          lock         <= 1'b0;
          if (fine_done) begin
            // Symbol boundary found; wins over fail and timeout.
            state        <= ST_LOCKED;
            time_syn_run <= 1'b0;
            fine_arm     <= 1'b0;
            lock         <= 1'b1;
            to_cnt       <= '0;
          end else if (fine_fail) begin
            state    <= ST_SEARCH;
            fine_arm <= 1'b0;
            to_cnt   <= '0;
            plat_cnt <= '0;
            miss_cnt <= '0;
          end else if (ena) begin
            if (to_cnt == FINE_LAST) begin
              state    <= ST_SEARCH;
              fine_arm <= 1'b0;
              tout     <= 1'b1;
              to_cnt   <= '0;
              plat_cnt <= '0;
              miss_cnt <= '0;
            end else begin
              to_cnt <= to_cnt + CNT_W'(1);
            end
          end else begin
            to_cnt <= to_cnt;
          end
        end

        ST_LOCKED: begin
          // Held until the frame ends (cyc_i low).
          time_syn_run <= 1'b0;
          fine_arm     <= 1'b0;
          lock         <= 1'b1;
        end

        default: begin
          state        <= ST_IDLE;
          plat_cnt     <= '0;
          miss_cnt     <= '0;
          to_cnt       <= '0;
          time_syn_run <= 1'b0;
          fine_arm     <= 1'b0;
          lock         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_synch_ctrl.sv
// Directed testbench for synch_ctrl: linear stimulus, hand-computed results.
module tb_synch_ctrl;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        cyc_i;
  logic        ena;
  logic [23:0] P_mag;
  logic [23:0] R_metric;
  logic [4:0]  thres;
  logic        fine_done;
  logic        fine_fail;
  logic        time_syn_run;
  logic        freoff_ena;
  logic        fine_arm;
  logic        lock;
  logic        tout;
  logic [2:0]  state_o;

  logic [4:0]  outs;
  int          checks = 0;
  int          failures = 0;
  int          freoff_seen = 0;
  int          tout_seen = 0;
  int          snap_f;
  int          snap_t;

  // {time_syn_run, freoff_ena, fine_arm, lock, tout}
  localparam logic [4:0] O_IDLE = 5'b00000;
  localparam logic [4:0] O_RUN  = 5'b10000;
  localparam logic [4:0] O_FRE  = 5'b11100;
  localparam logic [4:0] O_WAIT = 5'b10100;
  localparam logic [4:0] O_LOCK = 5'b00010;
  localparam logic [4:0] O_TOUT = 5'b10001;

  localparam logic [23:0] R0 = 24'h010000;
  localparam logic [23:0] HP = 24'h008000;  // exactly on threshold at thres=8
  localparam logic [23:0] MP = 24'h007FFF;  // one LSB below threshold

  synch_ctrl dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .cyc_i(cyc_i), .ena(ena),
    .P_mag(P_mag), .R_metric(R_metric), .thres(thres),
    .fine_done(fine_done), .fine_fail(fine_fail),
    .time_syn_run(time_syn_run), .freoff_ena(freoff_ena),
    .fine_arm(fine_arm), .lock(lock), .tout(tout), .state_o(state_o)
  );

  always #5 CLK_I = ~CLK_I;

  assign outs = {time_syn_run, freoff_ena, fine_arm, lock, tout};

  // Count pulse outputs between the active edges.
  always @(negedge CLK_I) begin
    if (freoff_ena === 1'b1) freoff_seen++;
    if (tout === 1'b1) tout_seen++;
  end

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_st(input string tag, input logic [2:0] s, input logic [4:0] o);
    check({tag, "_state"}, {29'd0, state_o}, {29'd0, s});
    check({tag, "_outs"}, {27'd0, outs}, {27'd0, o});
  endtask

  task automatic samples(input int n, input logic [23:0] p, input logic [23:0] r);
    for (int i = 0; i < n; i++) begin
      ena = 1'b1; P_mag = p; R_metric = r;
      tick();
    end
    ena = 1'b0;
  endtask

  task automatic to_search();
    cyc_i = 1'b0; tick();
    cyc_i = 1'b1; tick();
  endtask

  initial begin
    RST_I = 1'b1; cyc_i = 1'b0; ena = 1'b0; P_mag = 24'd0; R_metric = 24'd0;
    thres = 5'd8; fine_done = 1'b0; fine_fail = 1'b0;

    // Reset for three cycles; cyc_i high in the last one must not escape reset.
    tick(); expect_st("rst1", 3'd0, O_IDLE);
    tick(); expect_st("rst2", 3'd0, O_IDLE);
    cyc_i = 1'b1;
    tick(); expect_st("rst3", 3'd0, O_IDLE);
    RST_I = 1'b0;
    tick(); expect_st("search_entry", 3'd1, O_RUN);

    // ena low with hit data: no transition.
    P_mag = HP; R_metric = R0; tick(); expect_st("ena_low", 3'd1, O_RUN);

    // Clean plateau of 48 hits.
    snap_f = freoff_seen;
    samples(1, HP, R0);  expect_st("plat_first", 3'd2, O_RUN);
    samples(46, HP, R0); expect_st("plat_47", 3'd2, O_RUN);
    samples(1, HP, R0);  expect_st("plat_48", 3'd3, O_FRE);
    tick();              expect_st("wait_fine", 3'd3, O_WAIT);
    check("freoff_once", freoff_seen - snap_f, 32'd1);

    // fine_done and fine_fail together: done wins.
    fine_done = 1'b1; fine_fail = 1'b1; tick();
    fine_done = 1'b0; fine_fail = 1'b0;
    expect_st("lock_both", 3'd4, O_LOCK);
    samples(3, HP, R0);
    fine_fail = 1'b1; tick(); fine_fail = 1'b0;
    expect_st("lock_hold", 3'd4, O_LOCK);

    // Frame end and restart.
    cyc_i = 1'b0; tick(); expect_st("abort_lock", 3'd0, O_IDLE);
    cyc_i = 1'b1; tick(); expect_st("restart", 3'd1, O_RUN);

    // Plateau with interleaved misses (never three in a row): 48 hits complete.
    snap_f = freoff_seen;
    samples(1, HP, R0); samples(2, MP, R0);
    expect_st("two_miss", 3'd2, O_RUN);
    samples(1, HP, R0); samples(2, MP, R0);
    expect_st("miss_reset", 3'd2, O_RUN);
    samples(45, HP, R0); expect_st("miss_plat_47", 3'd2, O_RUN);
    samples(1, HP, R0);  expect_st("miss_plat_48", 3'd3, O_FRE);
    tick();
    check("freoff_once_miss", freoff_seen - snap_f, 32'd1);

    // Fine-timing timeout after 256 samples.
    snap_t = tout_seen;
    samples(255, HP, R0); expect_st("fine_255", 3'd3, O_WAIT);
    samples(1, HP, R0);   expect_st("fine_to", 3'd1, O_TOUT);
    tick();               expect_st("fine_to_after", 3'd1, O_RUN);
    check("fine_tout_once", tout_seen - snap_t, 32'd1);

    // Three consecutive misses at hit 20 abort the plateau.
    snap_f = freoff_seen;
    samples(19, HP, R0); samples(2, MP, R0);
    expect_st("miss2_hold", 3'd2, O_RUN);
    samples(1, MP, R0);  expect_st("miss3_abort", 3'd1, O_RUN);

    // Search timeout on the 4096th non-hit sample.
    snap_t = tout_seen;
    samples(4095, 24'd0, R0); expect_st("srch_4095", 3'd1, O_RUN);
    check("srch_no_early_tout", tout_seen - snap_t, 32'd0);
    samples(1, 24'd0, R0);    expect_st("srch_to", 3'd1, O_TOUT);
    samples(1, HP, R0);       expect_st("hit_after_to", 3'd2, O_RUN);

    // cyc_i drop at plateau sample 47 (hit presented as the 48th).
    samples(46, HP, R0);
    cyc_i = 1'b0; ena = 1'b1; tick(); ena = 1'b0;
    expect_st("drop_plat", 3'd0, O_IDLE);
    tick();
    check("drop_no_freoff", freoff_seen - snap_f, 32'd0);
    cyc_i = 1'b1; tick(); expect_st("drop_restart", 3'd1, O_RUN);
    samples(47, HP, R0); expect_st("fresh_47", 3'd2, O_RUN);
    samples(1, HP, R0);  expect_st("fresh_48", 3'd3, O_FRE);

    // fine_fail alone returns to SEARCH; fine_done ignored in SEARCH.
    fine_fail = 1'b1; tick(); fine_fail = 1'b0;
    expect_st("fine_fail", 3'd1, O_RUN);
    fine_done = 1'b1; tick(); fine_done = 1'b0;
    expect_st("done_ignored", 3'd1, O_RUN);

    // Threshold edge cases.
    thres = 5'd0;  samples(1, 24'd0, 24'hFFFFFF); expect_st("thres0_hit", 3'd2, O_RUN);
    to_search();
    thres = 5'd16; samples(1, 24'd0, 24'd0);      expect_st("r0_hit", 3'd2, O_RUN);
    to_search();
    thres = 5'd31; samples(1, R0, R0);            expect_st("sat31_hit", 3'd2, O_RUN);
    to_search();
    thres = 5'd17; samples(1, R0, R0);            expect_st("sat17_hit", 3'd2, O_RUN);
    to_search();
    thres = 5'd16; samples(1, 24'h00FFFF, R0);    expect_st("thr16_miss", 3'd1, O_RUN);
    thres = 5'd16; samples(1, 24'hFFFFFF, 24'hFFFFFF); expect_st("max_hit", 3'd2, O_RUN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
